// File: rtl/fir_mac_stage.sv
// fir_mac_stage: per-frame FIR multiply-accumulate behind the sample queue.
// Define FIR_SAT_EN to saturate the result; otherwise the low bits wrap.
module fir_mac_stage #(
    parameter int N_TAPS = 1021,
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10,
    parameter int ACC_W  = 40
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     sequencing,
    input  logic signed [DATA_W-1:0] smpl_in,
    output logic        [ADDR_W-1:0] coeff_addr,
    input  logic signed [DATA_W-1:0] coeff,
    output logic signed [DATA_W-1:0] smpl_out,
    output logic                     out_vld,
    output logic                     busy
);

    localparam int FRAC = DATA_W - 1;
    localparam logic [ADDR_W-1:0] LAST_TAP = ADDR_W'(N_TAPS - 1);

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        DRAIN,
        WAIT_LOW
    } state_t;

    state_t state;
    state_t state_nxt;

    logic        [ADDR_W-1:0]   tap_cnt;
    logic signed [DATA_W-1:0]   smpl_d;
    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    acc;
    logic signed [DATA_W-1:0]   lim;
    logic                       v_d;
    logic                       v_p;
    logic                       lst_d;
    logic                       lst_p;
    logic                       lst_a;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (sequencing) begin
                    state_nxt = (N_TAPS == 1) ? DRAIN : MAC;
                end
            end
            MAC: begin
                if (!sequencing) begin
                    state_nxt = IDLE;
                end else if (tap_cnt == LAST_TAP) begin
                    state_nxt = DRAIN;
                end
            end
            // Hold DRAIN through the result cycle so busy covers out_vld.
            DRAIN: begin
                if (out_vld) begin
                    state_nxt = WAIT_LOW;
                end
            end
            WAIT_LOW: begin
                if (!sequencing) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy       = 1'b0;
        coeff_addr = '0;
        unique case (state)
            MAC: begin
                busy       = 1'b1;
                coeff_addr = tap_cnt;
            end
            DRAIN: begin
                busy = 1'b1;
            end
            default: begin
                busy       = 1'b0;
                coeff_addr = '0;
            end
        endcase
    end

`ifdef FIR_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN =
        {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    logic signed [ACC_W-1:0] shifted;

    assign shifted = acc >>> FRAC;

    always_comb begin
        lim = shifted[DATA_W-1:0];
        unique case (1'b1)
            (shifted > SAT_MAX): lim = {1'b0, {(DATA_W-1){1'b1}}};
            (shifted < SAT_MIN): lim = {1'b1, {(DATA_W-1){1'b0}}};
            default:             lim = shifted[DATA_W-1:0];
        endcase
    end
`else
    assign lim = DATA_W'(acc >>> FRAC);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            tap_cnt  <= '0;
            smpl_d   <= '0;
            prod     <= '0;
            acc      <= '0;
            v_d      <= 1'b0;
            v_p      <= 1'b0;
            lst_d    <= 1'b0;
            lst_p    <= 1'b0;
            lst_a    <= 1'b0;
            smpl_out <= '0;
            out_vld  <= 1'b0;
        end else begin
            prod    <= smpl_d * coeff;
            v_p     <= v_d;
            lst_p   <= v_d & lst_d;
            lst_a   <= v_p & lst_p;
            out_vld <= lst_a;
            if (v_p) begin
                acc <= acc + ACC_W'(prod);
            end
            if (lst_a) begin
                smpl_out <= lim;
            end
            v_d     <= 1'b0;
            lst_d   <= 1'b0;
            tap_cnt <= '0;
            if (state == IDLE && sequencing) begin
                smpl_d  <= smpl_in;
                v_d     <= 1'b1;
                lst_d   <= (N_TAPS == 1);
                tap_cnt <= ADDR_W'(1);
                acc     <= '0;
            end
            // A frame that ends early is dropped before it reaches the output.
            if (state == MAC) begin
                if (sequencing) begin
                    smpl_d  <= smpl_in;
                    v_d     <= 1'b1;
                    lst_d   <= (tap_cnt == LAST_TAP);
                    tap_cnt <= tap_cnt + 1'b1;
                end else begin
                    v_p   <= 1'b0;
                    lst_p <= 1'b0;
                    lst_a <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_fir_mac_stage.sv
// tb_fir_mac_stage: directed frames against a frame-level reference model.
// Build with FIR_SAT_EN defined to check the saturating variant.
module tb_fir_mac_stage;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        sequencing;
    logic [15:0] smpl_in;
    logic [9:0]  coeff_addr;
    logic [15:0] coeff;
    logic [15:0] smpl_out;
    logic        out_vld;
    logic        busy;

    fir_mac_stage #(
        .N_TAPS(N),
        .DATA_W(16),
        .ADDR_W(10),
        .ACC_W (40)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sequencing(sequencing),
        .smpl_in   (smpl_in),
        .coeff_addr(coeff_addr),
        .coeff     (coeff),
        .smpl_out  (smpl_out),
        .out_vld   (out_vld),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    logic [15:0] rom [0:1023];

    always @(posedge clk) coeff <= rom[coeff_addr];

    int checks = 0;
    int errors = 0;

    task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // Reference: a frame is N consecutive samples; tap i pairs with rom[i].
    typedef enum int {M_IDLE, M_MAC, M_POST} mph_t;

    mph_t        ph = M_IDLE;
    int          e = 0;
    int          out_e = -10;
    bit          started = 0;
    logic [15:0] mq[$];
    logic [15:0] m_smpl = '0;
    logic [15:0] m_res = '0;

    function automatic logic [15:0] frame_result();
        longint s = 0;
        longint sh;
        foreach (mq[i]) begin
            s += longint'($signed(mq[i])) * longint'($signed(rom[i]));
        end
        sh = s >>> 15;
`ifdef FIR_SAT_EN
        if (sh > 32767) sh = 32767;
        else if (sh < -32768) sh = -32768;
`endif
        return 16'(sh);
    endfunction

    always @(posedge clk) begin
        e++;
        if (rst) begin
            ph = M_IDLE;
            mq.delete();
            m_smpl = '0;
            out_e = -10;
            started = 1;
        end else begin
            case (ph)
                M_IDLE: begin
                    if (sequencing) begin
                        mq.delete();
                        mq.push_back(smpl_in);
                        ph = M_MAC;
                    end
                end
                M_MAC: begin
                    if (sequencing) begin
                        mq.push_back(smpl_in);
                        if (mq.size() == N) begin
                            m_res = frame_result();
                            out_e = e + 3;
                            ph = M_POST;
                        end
                    end else begin
                        ph = M_IDLE;
                    end
                end
                default: begin
                    if (e == out_e) m_smpl = m_res;
                    else if (e > out_e + 1 && !sequencing) ph = M_IDLE;
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("vld", out_vld, ph == M_POST && e == out_e);
            chk("busy", busy, ph == M_MAC || (ph == M_POST && e <= out_e));
            chk("smpl_out", smpl_out, m_smpl);
            if (ph != M_POST) chk("addr", coeff_addr, ph == M_MAC ? mq.size() : 0);
        end
    end

    logic [15:0] stim [0:7];
    int          nv;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rom(logic [15:0] c0, logic [15:0] c1,
                           logic [15:0] c2, logic [15:0] c3);
        rom[0] = c0;
        rom[1] = c1;
        rom[2] = c2;
        rom[3] = c3;
    endtask

    task automatic set_stim(logic [15:0] s0, logic [15:0] s1,
                            logic [15:0] s2, logic [15:0] s3);
        stim[0] = s0;
        stim[1] = s1;
        stim[2] = s2;
        stim[3] = s3;
    endtask

    task automatic burst(int n);
        for (int i = 0; i < n; i++) begin
            sequencing = 1'b1;
            smpl_in = stim[i];
            tick();
        end
        sequencing = 1'b0;
        smpl_in = 16'hDEAD;
    endtask

    task automatic expect_out(string nm, logic [15:0] exp, int extra);
        int lat = -1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (out_vld) begin
                lat = k + extra;
                break;
            end
        end
        chk({nm, "_lat"}, lat, 3);
        chk(nm, smpl_out, exp);
        tick();
        chk({nm, "_busy_drop"}, busy, 0);
    endtask

    task automatic gap(int n, output int cnt);
        cnt = 0;
        repeat (n) begin
            tick();
            if (out_vld) cnt++;
        end
    endtask

    logic [15:0] exp_pos;
    logic [15:0] exp_neg;

    initial begin
`ifdef FIR_SAT_EN
        exp_pos = 16'h7FFF;
        exp_neg = 16'h8000;
`else
        exp_pos = 16'hFFF8;
        exp_neg = 16'h0004;
`endif
        rst = 1'b1;
        sequencing = 1'b0;
        smpl_in = '0;
        for (int i = 0; i < 1024; i++) rom[i] = '0;
        for (int i = 0; i < 8; i++) stim[i] = '0;
        tick();
        tick();
        chk("rst_smpl", smpl_out, 0);
        chk("rst_vld", out_vld, 0);
        chk("rst_busy", busy, 0);
        chk("rst_addr", coeff_addr, 0);
        rst = 1'b0;
        gap(2, nv);

        set_rom(16'h4000, 16'h4000, 16'h4000, 16'h4000);
        set_stim(16'h1000, 16'h1000, 16'h1000, 16'h1000);
        burst(4);
        expect_out("basic", 16'h2000, 0);
        chk("model_basic", m_res, 16'h2000);
        gap(3, nv);

        set_rom(16'h7FFF, 16'h0000, 16'h0000, 16'h0000);
        set_stim(16'h0100, 16'h0200, 16'h0300, 16'h0400);
        burst(4);
        expect_out("align", 16'h00FF, 0);
        chk("model_align", m_res, 16'h00FF);
        gap(3, nv);

        set_rom(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
        set_stim(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
        burst(4);
        expect_out("ovf_pos", exp_pos, 0);
        chk("model_ovf_pos", m_res, exp_pos);
        gap(3, nv);

        set_stim(16'h8000, 16'h8000, 16'h8000, 16'h8000);
        burst(4);
        expect_out("ovf_neg", exp_neg, 0);
        chk("model_ovf_neg", m_res, exp_neg);
        gap(3, nv);

        set_stim(16'h1111, 16'h2222, 16'h0000, 16'h0000);
        burst(2);
        gap(6, nv);
        chk("abort_novld", nv, 0);
        chk("abort_hold", smpl_out, exp_neg);

        set_rom(16'h4000, 16'h4000, 16'h4000, 16'h4000);
        set_stim(16'h1000, 16'h2000, 16'h3000, 16'h4000);
        burst(4);
        expect_out("post_abort", 16'h5000, 0);
        gap(3, nv);

        set_stim(16'h1000, 16'h1000, 16'h1000, 16'h1000);
        stim[4] = 16'h7000;
        stim[5] = 16'h7000;
        burst(6);
        expect_out("long", 16'h2000, 2);
        gap(6, nv);
        chk("long_single", nv, 0);

        sequencing = 1'b1;
        smpl_in = 16'h1234;
        tick();
        smpl_in = 16'h5678;
        tick();
        rst = 1'b1;
        tick();
        chk("rst_mid_smpl", smpl_out, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_vld", out_vld, 0);
        rst = 1'b0;
        sequencing = 1'b0;
        gap(8, nv);
        chk("rst_nostale", nv, 0);
        chk("rst_hold", smpl_out, 0);

        set_rom(16'h7FFF, 16'h0000, 16'h0000, 16'h0000);
        set_stim(16'h0100, 16'h0200, 16'h0300, 16'h0400);
        burst(4);
        expect_out("recover", 16'h00FF, 0);
        gap(3, nv);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
